// File: rtl/group_mac_drain.sv
// group_mac_drain: captures the final GROUP_NB-lane accumulator vector from
// group_mac and streams the lanes out one per valid/ready handshake, lane 0
// first. Each lane is rounded from Q(IMG_FIXED+KER_FIXED) down to Q(IMG_FIXED)
// and saturated to a signed IMG_WIDTH word.
// Optional build macro: GROUP_MAC_DRAIN_RELU_EN clamps negative output words
// to zero after saturation. out_sat still reports only range saturation.
module group_mac_drain #(
  parameter int GROUP_NB  = 4,
  parameter int IMG_WIDTH = 16,
  parameter int KER_WIDTH = 8,
  parameter int IMG_FIXED = IMG_WIDTH / 4,
  parameter int KER_FIXED = KER_WIDTH / 2,
  localparam int LW = IMG_WIDTH + KER_WIDTH + 1,
  localparam int IW = (GROUP_NB > 1) ? $clog2(GROUP_NB) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [GROUP_NB*LW-1:0] result,
  input  logic                   last,
  output logic                   busy,
  output logic [IMG_WIDTH-1:0]   out_data,
  output logic [IW-1:0]          out_idx,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   out_sat,
  output logic                   overrun
);

  // Accumulator fraction is IMG_FIXED+KER_FIXED; output keeps IMG_FIXED.
  localparam int ACC_FIXED = IMG_FIXED + KER_FIXED;
  localparam int SHIFT     = ACC_FIXED - IMG_FIXED;

  localparam logic signed [LW:0] RND     = (LW+1)'(2 ** (SHIFT - 1));
  localparam logic signed [LW:0] SAT_MAX = (LW+1)'(2 ** (IMG_WIDTH - 1) - 1);
  localparam logic signed [LW:0] SAT_MIN = (LW+1)'(-(2 ** (IMG_WIDTH - 1)));

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  localparam logic [IW-1:0] IDX_LAST = IW'(GROUP_NB - 1);

  logic [0:0]             state_reg;
  logic [GROUP_NB*LW-1:0] shadow_reg;
  logic [IW-1:0]          idx_reg;
  logic                   overrun_reg;

  logic                   sending;
  logic                   handshake;
  logic                   idx_is_last;

  logic signed [LW-1:0]   lanes [GROUP_NB];
  logic signed [LW-1:0]   lane;
  logic signed [LW:0]     widened;
  logic signed [LW:0]     rounded;
  logic [IMG_WIDTH-1:0]   sat_data;
  logic                   sat_flag;

  assign sending     = (state_reg == S_SEND);
  assign handshake   = sending && out_ready;
  assign idx_is_last = (idx_reg == IDX_LAST);

  // Unpack the shadow vector into per-lane views.
  generate
    for (genvar gi = 0; gi < GROUP_NB; gi++) begin : g_lane
      assign lanes[gi] = shadow_reg[gi*LW +: LW];
    end
  endgenerate

  // Select the lane addressed by the registered index.
  always_comb begin
    lane = lanes[0];
    for (int i = 0; i < GROUP_NB; i++) begin
      if (idx_reg == IW'(i)) begin
        lane = lanes[i];
      end
    end
  end

  // Round half up on one extra bit so the add cannot wrap, then saturate.
  always_comb begin
    widened  = {lane[LW-1], lane} + RND;
    rounded  = widened >>> SHIFT;
    sat_flag = 1'b0;
    sat_data = rounded[IMG_WIDTH-1:0];
    if (rounded > SAT_MAX) begin
      sat_data = {1'b0, {(IMG_WIDTH-1){1'b1}}};
      sat_flag = 1'b1;
    end else if (rounded < SAT_MIN) begin
      sat_data = {1'b1, {(IMG_WIDTH-1){1'b0}}};
      sat_flag = 1'b1;
    end
  end

`ifdef GROUP_MAC_DRAIN_RELU_EN
  // Negative words become zero; this is an activation, not a saturation.
  always_comb begin
    out_data = sat_data[IMG_WIDTH-1] ? '0 : sat_data;
  end
`else
  // Signed words pass through unchanged.
  always_comb begin
    out_data = sat_data;
  end
`endif

  assign out_sat   = sat_flag;
  assign out_idx   = idx_reg;
  assign out_valid = sending;
  assign busy      = sending;
  assign out_last  = sending && idx_is_last;
  assign overrun   = overrun_reg;

  // Capture/drain state machine; a last pulse arriving on the final handshake
  // reloads the shadow directly so back-to-back vectors stream with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      shadow_reg  <= '0;
      idx_reg     <= '0;
      overrun_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (last) begin
            shadow_reg <= result;
            idx_reg    <= '0;
            state_reg  <= S_SEND;
          end
        end
        default: begin
          if (handshake) begin
            if (idx_is_last) begin
              idx_reg <= '0;
              if (last) begin
                shadow_reg <= result;
              end else begin
                state_reg <= S_IDLE;
              end
            end else begin
              idx_reg <= idx_reg + IW'(1);
            end
          end
          if (last && !(handshake && idx_is_last)) begin
            overrun_reg <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_group_mac_drain.sv
// Bench for group_mac_drain: table of lane vectors with hand-computed results,
// a scoreboard queue checked on every accepted word, and short sequences for
// backpressure, back-to-back loads, overrun and asynchronous reset.
module tb_group_mac_drain;

  localparam int NB = 4;
  localparam int LW = 25;

  logic          clk;
  logic          rst_n;
  logic [NB*LW-1:0] result;
  logic          last;
  logic          busy;
  logic [15:0]   out_data;
  logic [1:0]    out_idx;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          out_sat;
  logic          overrun;

  group_mac_drain dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .result    (result),
    .last      (last),
    .busy      (busy),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_sat   (out_sat),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][31:0] raw;
    logic [3:0][15:0] data;
    logic [3:0]       sat;
  } vec_t;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  idx;
    logic        lst;
    logic        sat;
  } exp_t;

  localparam int NVEC = 5;
  vec_t vecs [NVEC];
  exp_t sb [$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] adj(input logic [15:0] d);
`ifdef GROUP_MAC_DRAIN_RELU_EN
    return d[15] ? 16'h0000 : d;
`else
    return d;
`endif
  endfunction

  task automatic set_vec(input int k, input int r0, input int r1, input int r2, input int r3,
                         input logic [15:0] d0, input logic [15:0] d1,
                         input logic [15:0] d2, input logic [15:0] d3,
                         input logic [3:0] s);
    vecs[k].raw  = {r3, r2, r1, r0};
    vecs[k].data = {d3, d2, d1, d0};
    vecs[k].sat  = s;
  endtask

  // Drive one last pulse with vector k; optionally push its expected words.
  task automatic fire(input int k, input bit push);
    for (int i = 0; i < NB; i++) begin
      result[i*LW +: LW] = vecs[k].raw[i][LW-1:0];
    end
    if (push) begin
      for (int i = 0; i < NB; i++) begin
        sb.push_back('{data: adj(vecs[k].data[i]), idx: 2'(i), lst: (i == NB-1), sat: vecs[k].sat[i]});
      end
    end
    last = 1'b1;
    @(posedge clk);
    #1;
    last = 1'b0;
  endtask

  task automatic wait_idx(input logic [1:0] target);
    int n = 0;
    while (out_idx !== target && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wait_idx_timeout", 32'(n < 20), 32'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", 32'(n < 100), 32'd1);
    chk("drain_busy", 32'(busy), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);
  endtask

  // Scoreboard: every word accepted at the next rising edge is compared here.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", 32'(out_idx), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("word idx=%0d data=%h last=%b sat=%b (expect data=%h sat=%b)",
                 out_idx, out_data, out_last, out_sat, e.data, e.sat);
        chk("word_data", 32'(out_data), 32'(e.data));
        chk("word_idx",  32'(out_idx),  32'(e.idx));
        chk("word_last", 32'(out_last), 32'(e.lst));
        chk("word_sat",  32'(out_sat),  32'(e.sat));
      end
    end
  end

  initial begin
    set_vec(0, 128, 256, 384, 512, 16'h0008, 16'h0010, 16'h0018, 16'h0020, 4'b0000);
    set_vec(1, 24, 23, -24, -25, 16'h0002, 16'h0001, 16'hFFFF, 16'hFFFE, 4'b0000);
    set_vec(2, 640000, -640000, -8, -9, 16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF, 4'b0011);
    set_vec(3, 524279, 524280, -524288, -524297, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 4'b1010);
    set_vec(4, 0, 8, 7, -9, 16'h0000, 16'h0001, 16'h0000, 16'hFFFF, 4'b0000);

    rst_n     = 1'b0;
    last      = 1'b0;
    result    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",     32'(busy),      32'd0);
    chk("rst_valid",    32'(out_valid), 32'd0);
    chk("rst_last",     32'(out_last),  32'd0);
    chk("rst_sat",      32'(out_sat),   32'd0);
    chk("rst_overrun",  32'(overrun),   32'd0);
    chk("rst_data",     32'(out_data),  32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy), 32'd0);

    // Table-driven vectors with ready held high.
    out_ready = 1'b1;
    for (int k = 0; k < NVEC; k++) begin
      fire(k, 1'b1);
      chk("latency_valid", 32'(out_valid), 32'd1);
      chk("latency_idx",   32'(out_idx),   32'd0);
      chk("latency_busy",  32'(busy),      32'd1);
      wait_drain();
    end

    // Backpressure on lane 1 for three cycles.
    out_ready = 1'b0;
    fire(0, 1'b1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_idx_enter", 32'(out_idx), 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("bp_idx_hold",  32'(out_idx),   32'd1);
      chk("bp_data_hold", 32'(out_data),  32'h0010);
      chk("bp_valid",     32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_idx_next", 32'(out_idx), 32'd2);
    wait_drain();

    // last coincident with the final handshake reloads with no bubble.
    fire(0, 1'b1);
    wait_idx(2'd3);
    fire(1, 1'b1);
    chk("b2b_valid",   32'(out_valid), 32'd1);
    chk("b2b_idx",     32'(out_idx),   32'd0);
    chk("b2b_data",    32'(out_data),  32'(adj(16'h0002)));
    chk("b2b_overrun", 32'(overrun),   32'd0);
    // last mid-vector is dropped and flagged.
    wait_idx(2'd1);
    fire(4, 1'b0);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_idx",  32'(out_idx), 32'd2);
    wait_drain();
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // Asynchronous reset in the middle of a drain.
    fire(0, 1'b1);
    wait_idx(2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid",   32'(out_valid), 32'd0);
    chk("arst_busy",    32'(busy),      32'd0);
    chk("arst_data",    32'(out_data),  32'd0);
    chk("arst_overrun", 32'(overrun),   32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_busy",  32'(busy),      32'd0);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    fire(2, 1'b1);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
